// File: rtl/rfid_rx_pkg.sv
// Shared definitions for the reader-to-tag receive path: decoder FSM states
// and default counter geometry.
package rfid_rx_pkg;

    localparam int CNT_W_DEF     = 10;
    localparam int DELIM_MIN_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELIM = 3'd1,
        TARI  = 3'd2,
        RTCAL = 3'd3,
        CAL   = 3'd4,
        DATA  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the demodulated envelope plus a history flop.
// It produces one-cycle rise/fall pulses. All flops reset high, which is the idle level of the line.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

endmodule

// File: rtl/pie_decoder.sv
// PIE receive front end. It validates the delimiter and measures Tari, RTcal and the optional TRcal.
// It then emits one bit per data symbol with a single-cycle bitclk strobe.
module pie_decoder
    import rfid_rx_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DELIM_MIN = DELIM_MIN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_en,
    input  logic             demodin,
    output logic             bitout,
    output logic             bitclk,
    output logic             pkt_start,
    output logic             rx_done,
    output logic             rx_err,
    output logic [CNT_W-1:0] trcal,
    output logic             trcal_valid
);

    localparam logic [CNT_W-1:0] DELIM_LIM = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rtcal;
    logic [CNT_W-1:0] pivot;
    logic             rise;
    logic             fall;
    logic             cnt_sat;
    logic             timeout;
    logic             cnt_edge;
    logic [CNT_W+1:0] cal_limit;

    edge_sync u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .din   (demodin),
        .rise  (rise),
        .fall  (fall)
    );

    assign cnt_sat  = (cnt == '1);
    assign cnt_edge = (state == IDLE) ? fall : rise;

    // TRcal may be up to three RTcal long, so CAL waits 3*RTcal before declaring end of frame.
    assign cal_limit = ({2'b00, rtcal} << 1) + {2'b00, rtcal};

    always_comb begin
        timeout = 1'b0;
        if (state == CAL)
            timeout = ({2'b00, cnt} > cal_limit);
        else if (state == DATA)
            timeout = (cnt > rtcal);
    end

    // NOTE: every register here is updated with <= so all branches see the pre-edge values of cnt and state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rtcal       <= '0;
            pivot       <= '0;
            trcal       <= '0;
            trcal_valid <= 1'b0;
            bitout      <= 1'b0;
            bitclk      <= 1'b0;
            pkt_start   <= 1'b0;
            rx_done     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            bitclk    <= 1'b0;
            pkt_start <= 1'b0;
            rx_done   <= 1'b0;
            rx_err    <= 1'b0;

            if (!rx_en) begin
                state       <= IDLE;
                cnt         <= '0;
                rtcal       <= '0;
                pivot       <= '0;
                trcal_valid <= 1'b0;
                bitout      <= 1'b0;
            end else begin
                if (cnt_edge)
                    cnt <= CNT_ONE;
                else if (!cnt_sat)
                    cnt <= cnt + CNT_ONE;

                case (state)
                    IDLE:  if (fall) state <= DELIM;
                    DELIM: if (rise) state <= (cnt >= DELIM_LIM) ? TARI : IDLE;
                    TARI:  if (rise) state <= RTCAL;
                    RTCAL: if (rise) begin
                        rtcal       <= cnt;
                        pivot       <= cnt >> 1;
                        trcal       <= '0;
                        trcal_valid <= 1'b0;
                        pkt_start   <= 1'b1;
                        state       <= CAL;
                    end
                    CAL: if (rise) begin
                        if (cnt > rtcal) begin
                            trcal       <= cnt;
                            trcal_valid <= 1'b1;
                        end else begin
                            bitout <= (cnt > pivot);
                            bitclk <= 1'b1;
                        end
                        state <= DATA;
                    end
                    DATA: if (rise) begin
                        bitout <= (cnt > pivot);
                        bitclk <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase

                // A rise on the same cycle wins. Saturation outranks end of frame.
                if (state != IDLE && !rise) begin
                    if (cnt_sat) begin
                        rx_err <= 1'b1;
                        state  <= IDLE;
                    end else if (timeout) begin
                        rx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pie_decoder.sv
// Directed bench for pie_decoder. It uses a 10-bit decoder for the frame scenarios.
// A second 6-bit instance exercises counter saturation.
module tb_pie_decoder;
    import rfid_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic       demodin = 1'b1;
    logic       bitout, bitclk, pkt_start, rx_done, rx_err, trcal_valid;
    logic [9:0] trcal;

    logic       demod6 = 1'b1;
    logic       bitout6, bitclk6, pkt_start6, rx_done6, rx_err6, trcal_valid6;
    logic [5:0] trcal6;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int done_cyc = 0;
    int n_pkt = 0, n_done = 0, n_err = 0, n_both = 0;
    int n_err6 = 0, n_done6 = 0, n_other6 = 0;
    logic bits[$];
    int   bit_cyc[$];

    pie_decoder dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .demodin(demodin),
        .bitout(bitout), .bitclk(bitclk), .pkt_start(pkt_start), .rx_done(rx_done),
        .rx_err(rx_err), .trcal(trcal), .trcal_valid(trcal_valid)
    );

    pie_decoder #(.CNT_W(6)) dut6 (
        .clk(clk), .reset(reset), .rx_en(rx_en), .demodin(demod6),
        .bitout(bitout6), .bitclk(bitclk6), .pkt_start(pkt_start6), .rx_done(rx_done6),
        .rx_err(rx_err6), .trcal(trcal6), .trcal_valid(trcal_valid6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (bitclk) begin
            bits.push_back(bitout);
            bit_cyc.push_back(cyc);
        end
        if (pkt_start) n_pkt++;
        if (rx_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (rx_err) n_err++;
        if (rx_err && rx_done) n_both++;
        if (rx_err6) n_err6++;
        if (rx_done6) n_done6++;
        if (bitclk6 || pkt_start6) n_other6++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        bits.delete();
        bit_cyc.delete();
        n_pkt = 0; n_done = 0; n_err = 0; n_both = 0;
        n_err6 = 0; n_done6 = 0; n_other6 = 0;
    endtask

    task automatic drive(input logic v, input int n);
        if (v && !demodin) rise_cyc = cyc;
        demodin = v;
        repeat (n) @(negedge clk);
    endtask

    // One PIE symbol: high part, then a 5-cycle pulse; the next rise closes it.
    task automatic sym(input int len);
        drive(1'b1, len - 5);
        drive(1'b0, 5);
    endtask

    task automatic send_frame(input int delim, input int rt, input int tr,
                              input int data[4], input int nd);
        drive(1'b0, delim);
        sym(20);
        sym(rt);
        if (tr > 0) sym(tr);
        for (int i = 0; i < nd; i++) sym(data[i]);
        drive(1'b1, 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if ({bitout, bitclk, pkt_start, rx_done, rx_err, trcal_valid} !== 6'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b, expected 000000", {bitout, bitclk, pkt_start, rx_done, rx_err, trcal_valid}); end
        n_tests++; if (trcal !== 10'd0) begin n_fail++; $display("FAIL reset_trcal: got %0d, expected 0", trcal); end
        n_tests++; if (dut.state !== IDLE || dut.cnt !== 10'd0) begin n_fail++;
            $display("FAIL reset_state: got state %0d cnt %0d, expected IDLE 0", dut.state, dut.cnt); end
        n_tests++; if ({bitout6, trcal_valid6, trcal6} !== 8'd0) begin n_fail++;
            $display("FAIL reset_dut6: got %b, expected 0", {bitout6, trcal_valid6, trcal6}); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_preamble();
        logic exp_bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        clear_log();
        send_frame(25, 50, 100, '{35, 20, 35, 35}, 4);
        repeat (100) @(negedge clk);
        n_tests++; if (n_pkt != 1) begin n_fail++; $display("FAIL pre_pkt_start: got %0d pulses, expected 1", n_pkt); end
        n_tests++; if (trcal !== 10'd100 || trcal_valid !== 1'b1) begin n_fail++;
            $display("FAIL pre_trcal: got %0d valid %b, expected 100 valid 1", trcal, trcal_valid); end
        n_tests++; if (bits.size() != 4) begin n_fail++; $display("FAIL pre_bit_count: got %0d, expected 4", bits.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bits[i] !== exp_bits[i]) begin n_fail++;
                $display("FAIL pre_bit%0d: got %b, expected %b", i, bits[i], exp_bits[i]); end
        end
        n_tests++; if (bit_cyc[3] - rise_cyc != 3) begin n_fail++;
            $display("FAIL pre_latency: got %0d cycles, expected 3", bit_cyc[3] - rise_cyc); end
        n_tests++; if (n_done != 1 || done_cyc - rise_cyc != 54) begin n_fail++;
            $display("FAIL pre_rx_done: got %0d pulses at +%0d, expected 1 at +54", n_done, done_cyc - rise_cyc); end
        n_tests++; if (n_err != 0 || n_both != 0 || dut.state !== IDLE) begin n_fail++;
            $display("FAIL pre_end: got err %0d both %0d state %0d, expected 0 0 IDLE", n_err, n_both, dut.state); end
    endtask

    task automatic test_no_trcal();
        clear_log();
        send_frame(25, 50, 0, '{20, 35, 0, 0}, 2);
        repeat (80) @(negedge clk);
        n_tests++; if (trcal_valid !== 1'b0 || trcal !== 10'd0) begin n_fail++;
            $display("FAIL sync_trcal: got %0d valid %b, expected 0 valid 0", trcal, trcal_valid); end
        n_tests++; if (bits.size() != 2 || bits[0] !== 1'b0 || bits[1] !== 1'b1) begin n_fail++;
            $display("FAIL sync_bits: got %0d bits first %b second %b, expected 2 bits 0 1", bits.size(), bits[0], bits[1]); end
        n_tests++; if (n_pkt != 1 || n_done != 1) begin n_fail++;
            $display("FAIL sync_pulses: got pkt %0d done %0d, expected 1 1", n_pkt, n_done); end
    endtask

    task automatic test_short_delim();
        clear_log();
        send_frame(5, 50, 100, '{35, 20, 0, 0}, 2);
        repeat (80) @(negedge clk);
        n_tests++; if (n_pkt != 0 || bits.size() != 0 || n_done != 0) begin n_fail++;
            $display("FAIL short_delim: got pkt %0d bits %0d done %0d, expected 0 0 0", n_pkt, bits.size(), n_done); end
        n_tests++; if (dut.state !== IDLE) begin n_fail++;
            $display("FAIL short_delim_state: got %0d, expected IDLE", dut.state); end
    endtask

    task automatic test_pivot();
        clear_log();
        send_frame(25, 51, 0, '{25, 26, 0, 0}, 2);
        repeat (80) @(negedge clk);
        n_tests++; if (dut.pivot !== 10'd25) begin n_fail++; $display("FAIL pivot_value: got %0d, expected 25", dut.pivot); end
        n_tests++; if (bits.size() != 2 || bits[0] !== 1'b0 || bits[1] !== 1'b1) begin n_fail++;
            $display("FAIL pivot_bits: got %0d bits first %b second %b, expected 2 bits 0 1", bits.size(), bits[0], bits[1]); end
    endtask

    task automatic test_saturation();
        clear_log();
        @(negedge clk);
        demod6 = 1'b0;
        repeat (70) @(negedge clk);
        demod6 = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++; if (n_err6 != 1) begin n_fail++; $display("FAIL sat_rx_err: got %0d pulses, expected 1", n_err6); end
        n_tests++; if (n_done6 != 0 || n_other6 != 0) begin n_fail++;
            $display("FAIL sat_other: got done %0d strobes %0d, expected 0 0", n_done6, n_other6); end
        n_tests++; if (dut6.state !== IDLE) begin n_fail++; $display("FAIL sat_state: got %0d, expected IDLE", dut6.state); end
    endtask

    task automatic test_interrupt(input logic use_reset);
        int exp_trcal = use_reset ? 0 : 100;
        clear_log();
        drive(1'b0, 25); sym(20); sym(50); sym(100); sym(35); sym(35);
        drive(1'b1, 10);
        n_tests++; if (bits.size() != 2 || bitout !== 1'b1) begin n_fail++;
            $display("FAIL intr%0d_pre: got %0d bits bitout %b, expected 2 bits bitout 1", use_reset, bits.size(), bitout); end
        if (use_reset) begin
            reset = 1'b1; @(negedge clk); reset = 1'b0;
        end else begin
            rx_en = 1'b0; repeat (2) @(negedge clk);
        end
        n_tests++; if (bitout !== 1'b0 || trcal_valid !== 1'b0 || dut.state !== IDLE) begin n_fail++;
            $display("FAIL intr%0d_clear: got bitout %b valid %b state %0d, expected 0 0 IDLE", use_reset, bitout, trcal_valid, dut.state); end
        n_tests++; if (trcal !== 10'(exp_trcal)) begin n_fail++;
            $display("FAIL intr%0d_trcal: got %0d, expected %0d", use_reset, trcal, exp_trcal); end
        rx_en = 1'b1;
        drive(1'b1, 20); drive(1'b0, 5); sym(35); drive(1'b1, 80);
        n_tests++; if (bits.size() != 2 || n_done != 0 || n_err != 0) begin n_fail++;
            $display("FAIL intr%0d_quiet: got bits %0d done %0d err %0d, expected 2 0 0", use_reset, bits.size(), n_done, n_err); end
        send_frame(25, 50, 100, '{20, 35, 35, 0}, 3);
        repeat (80) @(negedge clk);
        n_tests++; if (bits.size() != 5 || bits[2] !== 1'b0 || bits[3] !== 1'b1 || bits[4] !== 1'b1) begin n_fail++;
            $display("FAIL intr%0d_next_bits: got %0d bits %b%b%b, expected 5 bits 011", use_reset, bits.size(), bits[2], bits[3], bits[4]); end
        n_tests++; if (trcal !== 10'd100 || trcal_valid !== 1'b1 || n_pkt != 2) begin n_fail++;
            $display("FAIL intr%0d_next_cal: got trcal %0d valid %b pkt %0d, expected 100 1 2", use_reset, trcal, trcal_valid, n_pkt); end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_no_trcal();
        test_short_delim();
        test_pivot();
        test_saturation();
        test_interrupt(1'b1);
        test_interrupt(1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
